// File: rtl/alu_exec_pkg.sv
// Shared ALU control codes and execution-unit FSM state encoding.
// Users of the ALUControl decoder import this package for the same constants.
package alu_exec_pkg;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluMult = 4'b0101;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSll  = 4'b1000;
  localparam logic [3:0] AluSrl  = 4'b1001;
  localparam logic [3:0] AluSra  = 4'b1010;
  localparam logic [3:0] AluDiv  = 4'b1011;
  localparam logic [3:0] AluNor  = 4'b1100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative signed multiply / restoring divide datapath, one bit per step.
// Operates on magnitudes; sign fix is applied combinationally on the final step.
// Divider logic exists only when ALU_EXEC_DIV_EN is defined.
module alu_muldiv_seq
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
`ifdef ALU_EXEC_DIV_EN
  input  logic             is_div,
`endif
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             neg_res_q;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
`ifdef ALU_EXEC_DIV_EN
  logic             is_div_q, neg_a_q, b_zero_q;
  logic [WIDTH:0]   shifted, diff;
`endif

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  // Load magnitudes/signs on acceptance, then advance one iteration per busy cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
      is_div_q  <= 1'b0;
      neg_a_q   <= 1'b0;
      b_zero_q  <= 1'b0;
`endif
    end else if (load) begin
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= mag(a);
      b_q       <= mag(b);
      neg_res_q <= a[WIDTH-1] ^ b[WIDTH-1];
`ifdef ALU_EXEC_DIV_EN
      is_div_q  <= is_div;
      neg_a_q   <= a[WIDTH-1];
      b_zero_q  <= (b == '0);
`endif
    end else if (step) begin
      count_q <= count_q + 1'b1;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // One iteration: shift-add for mult (hi=partial sum, lo=multiplier),
  // restoring subtract for div (hi=remainder, lo=dividend/quotient)
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    hi_d = sum[WIDTH:1];
    lo_d = {sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_EXEC_DIV_EN
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    if (is_div_q) begin
      hi_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
    end
`endif
  end

  // Sign-fixed final result, registered by the top on the last step
  always_comb begin
    last = (count_q == CntW'(WIDTH - 1));
    prod = {hi_d, lo_d};
    if (neg_res_q) prod = -prod;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef ALU_EXEC_DIV_EN
    if (is_div_q) begin
      // Divide by zero: quotient all ones, remainder = A falls out naturally
      res_lo = b_zero_q ? '1 : (neg_res_q ? -lo_d : lo_d);
      res_hi = neg_a_q ? -hi_d : hi_d;
    end
`endif
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops plus iterative signed mult/div with
// Ready/Busy/Done handshake. Divide support enabled by macro ALU_EXEC_DIV_EN.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Shamt,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, hi_q, lo_q, alu_res, seq_hi, seq_lo;
  logic             zero_q, accept, is_mult, is_div, seq_last;

  assign accept  = Ready & Start;
  assign is_mult = (ALU_Control == AluMult);
`ifdef ALU_EXEC_DIV_EN
  assign is_div  = (ALU_Control == AluDiv);
`else
  assign is_div  = 1'b0;
`endif

  alu_muldiv_seq #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .load   (accept & (is_mult | is_div)),
`ifdef ALU_EXEC_DIV_EN
    .is_div (is_div),
`endif
    .step   (Busy),
    .a      (A),
    .b      (B),
    .last   (seq_last),
    .res_hi (seq_hi),
    .res_lo (seq_lo)
  );

  // Single-cycle result; invalid codes (and 1011 without divider) yield zero
  always_comb begin
    alu_res = '0;
    case (ALU_Control)
      AluAnd:  alu_res = A & B;
      AluOr:   alu_res = A | B;
      AluAdd:  alu_res = A + B;
      AluXor:  alu_res = A ^ B;
      AluSub:  alu_res = A - B;
      AluSlt:  alu_res[0] = ($signed(A) < $signed(B));
      AluSll:  alu_res = B << Shamt;
      AluSrl:  alu_res = B >> Shamt;
      AluSra:  alu_res = WIDTH'($signed(B) >>> Shamt);
      AluNor:  alu_res = ~(A | B);
      default: alu_res = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          if (is_mult)     state_d = StMul;
          else if (is_div) state_d = StDiv;
          else             state_d = StDone;
        end
      end
      StMul, StDiv: if (seq_last) state_d = StDone;
      StDone:       state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    Ready = (state_q == StIdle);
    Busy  = (state_q == StMul) || (state_q == StDiv);
    Done  = (state_q == StDone);
  end

  // Output registers: single-cycle ops on acceptance, mult/div on final step
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (accept && !(is_mult || is_div)) begin
      result_q <= alu_res;
      zero_q   <= (alu_res == '0);
    end else if (Busy && seq_last) begin
      hi_q     <= seq_hi;
      lo_q     <= seq_lo;
      result_q <= seq_lo;
      zero_q   <= (seq_lo == '0);
    end
  end

  assign Result = result_q;
  assign Zero   = zero_q;
  assign HI     = hi_q;
  assign LO     = lo_q;

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Start  input  1  operation request, sampled when Ready=1.
REQ-005 ALU_Control  input  4  operation code from ALUControl decoder.
REQ-006 A, B  input  WIDTH each  operands (A=rs, B=rt/immediate).
REQ-007 Shamt  input  5  shift amount for sll/srl/sra.
REQ-008 Ready  output  1  high only in IDLE; Start accepted only when high.
REQ-009 Busy  output  1  high in MUL or DIV; pipeline stall request.
REQ-010 Done  output  1  one-cycle pulse; Result/Zero/HI/LO valid.
REQ-011 Result  output  WIDTH  registered result.
REQ-012 Zero  output  1  registered (Result==0).
REQ-013 HI, LO  output  WIDTH each  mult/div result registers.

Function
REQ-014 Codes: 0000 and, 0001 or, 0010 add, 0100 xor, 0101 mult, 0110 sub, 0111 slt (signed, Result 1/0), 1000 sll B, 1001 srl B, 1010 sra B, 1011 div, 1100 nor; all others invalid.
REQ-015 FSM states IDLE, MUL, DIV, DONE; IDLE->DONE for single-cycle/invalid codes, IDLE->MUL on 0101, IDLE->DIV on 1011, MUL/DIV->DONE after WIDTH iterations, DONE->IDLE unconditionally.
REQ-016 Single-cycle op accepted at edge N SHALL assert Done in cycle N+1 with Result registered.
REQ-017 mult/div accepted at edge N SHALL assert Done in cycle N+WIDTH+1; Busy high cycles N+1..N+WIDTH.
REQ-018 add/sub SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-019 mult SHALL be signed: {HI,LO}=A*B full 2*WIDTH-bit product, via shift-add on magnitudes with final sign fix.
REQ-020 div SHALL be signed restoring: LO=quotient truncated toward zero, HI=remainder with sign of A.
REQ-021 div with B=0 SHALL still take WIDTH iterations and yield LO=all ones, HI=A.
REQ-022 mult/div SHALL set Result=LO; other ops SHALL leave HI/LO unchanged.
REQ-023 Invalid code SHALL give Result=0, Zero=1, Done after one cycle.
REQ-024 Start while Ready=0 SHALL be ignored; operands/code SHALL be latched at acceptance and later input changes ignored.
REQ-025 Result/Zero SHALL hold their value until the next Done.

Reset
REQ-026 Rst_n low SHALL immediately force IDLE, Ready=1, Busy=0, Done=0, Result=0, Zero=1, HI=0, LO=0, counter=0.
REQ-027 Reset during MUL/DIV SHALL abandon the operation with no Done pulse after release.
REQ-028 First Start SHALL be accepted on the first rising edge with Rst_n high.

Configuration
REQ-029 Macro ALU_EXEC_DIV_EN defined: div (1011) per REQ-020/021.
REQ-030 Macro ALU_EXEC_DIV_EN undefined: 1011 SHALL be treated as invalid (REQ-023), HI/LO unchanged, no divider logic synthesized.

Structure
REQ-031 Package alu_exec_pkg SHALL hold the 4-bit ALU_Control code constants and FSM state encoding, shared with ALUControl users.
REQ-032 Iterative mult/div datapath (shift register, counter, sign fix) SHALL be sub-module alu_muldiv_seq; op decode, FSM and output registers stay in alu_exec_unit.

Verification
REQ-033 Reset then add A=7,B=-3 -> Done next cycle, Result=4, Zero=0, HI=LO=0.
REQ-034 sub A=5,B=5 -> Result=0, Zero=1; slt A=-1,B=1 -> Result=1; sra B=0x80000000,Shamt=4 -> 0xF8000000.
REQ-035 mult A=-6,B=7 -> Busy 32 cycles, Done at N+33, HI=0xFFFFFFFF, LO=0xFFFFFFD6, Result=LO; Start mid-Busy ignored.
REQ-036 div A=-7,B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; div A=9,B=0 -> LO=0xFFFFFFFF, HI=9 (with ALU_EXEC_DIV_EN); without macro -> Result=0, Done next cycle, HI/LO unchanged.
REQ-037 Rst_n pulsed low at iteration 10 of mult -> outputs at reset values immediately, no Done, next Start accepted normally.
REQ-038 Code 0011 -> Result=0, Zero=1, Done next cycle, HI/LO unchanged.
